// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: state encoding, IF/ID defaults and skid payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPC_W = 5;

  localparam logic [XLEN-1:0]  NOP_INSTR_DEF   = 16'h0800;
  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 5'b00000;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DROP,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [XLEN-1:0] instr, input logic [OPC_W-1:0] opc);
    return instr[XLEN-1 -: OPC_W] == opc;
  endfunction

endpackage

// File: rtl/dff_en.sv
// Single-bit flop with enable and synchronous active-low reset to a parameterised value.
module dff_en #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst)    q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC while decode is stalled.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t d,
  output logic         full,
  output fetch_entry_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/reg16bit.sv
// 16-bit register with enable and synchronous active-low reset to a parameterised value.
module reg16bit #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)    q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory handshake and IF/ID register.
// Optional macro FETCH_SKID_EN adds a one-entry skid that keeps fetching through decode stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0]  RESET_PC    = 16'h0000,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [XLEN-1:0]  NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            stallCtrl,
  input  logic            takeBranch,
  input  logic [XLEN-1:0] branchTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] instr_IFID,
  output logic [XLEN-1:0] PC_IFID,
  output logic [XLEN-1:0] PC2_IFID,
  output logic            halt_IFID,
  output logic            valid_IFID
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_inc;
  logic            ifid_en, halt_d, valid_d;
  logic [XLEN-1:0] instr_d, pc_ifid_d, pc2_ifid_d;
  logic            req_base;

  assign pc_inc    = pc + XLEN'(2);
  assign req_base  = (state == RUN) || (state == WAIT);
  assign imem_addr = pc;

`ifdef FETCH_SKID_EN
  logic         skid_full, skid_load, skid_clear;
  fetch_entry_t skid_d, skid_q;

  assign skid_d   = '{instr: imem_data, pc: pc};
  assign imem_req = req_base && !skid_full;

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (skid_d),
    .full  (skid_full),
    .q     (skid_q)
  );
`else
  // Without a skid, a stall only lets an already outstanding request finish (and be thrown away).
  assign imem_req = req_base && (!stallCtrl || (state == WAIT));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Event priority: freeze, branch, drop-pending, stall, skid unload, capture.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_en    = 1'b0;
    instr_d    = imem_data;
    pc_ifid_d  = pc;
    pc2_ifid_d = pc_inc;
    halt_d     = is_halt(imem_data, HALT_OPCODE);
    valid_d    = 1'b1;
`ifdef FETCH_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (!freeze) begin
      state_nxt = state;
    end else if (takeBranch) begin
      pc_nxt     = branchTarget;
      ifid_en    = 1'b1;
      instr_d    = NOP_INSTR;
      pc_ifid_d  = '0;
      pc2_ifid_d = '0;
      halt_d     = 1'b0;
      valid_d    = 1'b0;
`ifdef FETCH_SKID_EN
      skid_clear = 1'b1;
`endif
      if (state == DROP) state_nxt = imem_rdy ? RUN : DROP;
      else               state_nxt = (imem_req && !imem_rdy) ? DROP : RUN;
    end else if (state == DROP) begin
      if (imem_rdy) state_nxt = RUN;
    end else if (stallCtrl) begin
`ifdef FETCH_SKID_EN
      if (imem_req && imem_rdy) begin
        skid_load = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = RUN;
      end else if (imem_req) begin
        state_nxt = WAIT;
      end
`else
      if (imem_req && imem_rdy) state_nxt = RUN;
`endif
    end
`ifdef FETCH_SKID_EN
    else if (skid_full) begin
      ifid_en    = 1'b1;
      skid_clear = 1'b1;
      instr_d    = skid_q.instr;
      pc_ifid_d  = skid_q.pc;
      pc2_ifid_d = skid_q.pc + XLEN'(2);
      halt_d     = is_halt(skid_q.instr, HALT_OPCODE);
      state_nxt  = halt_d ? HALT : RUN;
    end
`endif
    else if (imem_req) begin
      if (imem_rdy) begin
        ifid_en   = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = halt_d ? HALT : RUN;
      end else begin
        state_nxt = WAIT;
      end
    end
  end

  reg16bit #(.RESET_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .rst(rst), .en(ifid_en), .d(instr_d), .q(instr_IFID)
  );
  reg16bit #(.RESET_VAL(16'h0000)) u_pc_ifid (
    .clk(clk), .rst(rst), .en(ifid_en), .d(pc_ifid_d), .q(PC_IFID)
  );
  reg16bit #(.RESET_VAL(16'h0000)) u_pc2_ifid (
    .clk(clk), .rst(rst), .en(ifid_en), .d(pc2_ifid_d), .q(PC2_IFID)
  );
  dff_en #(.RESET_VAL(1'b0)) u_halt (
    .clk(clk), .rst(rst), .en(ifid_en), .d(halt_d), .q(halt_IFID)
  );
  dff_en #(.RESET_VAL(1'b0)) u_valid (
    .clk(clk), .rst(rst), .en(ifid_en), .d(valid_d), .q(valid_IFID)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; a second instance covers PC wrap-around.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk, rst, freeze, stallCtrl, takeBranch, imem_rdy;
  logic [15:0] branchTarget, imem_data, imem_data2;
  logic        imem_req, halt_IFID, valid_IFID;
  logic [15:0] imem_addr, instr_IFID, PC_IFID, PC2_IFID;
  logic        imem_req2, halt_IFID2, valid_IFID2;
  logic [15:0] imem_addr2, instr_IFID2, PC_IFID2, PC2_IFID2;
  logic        halt_en;
  logic [15:0] halt_addr;
  int          checks, failures;

  // Memory returns {5'b00011, addr[10:0]}, or a HALT word at one chosen address.
  assign imem_data  = (halt_en && imem_addr == halt_addr) ? 16'h0000 : {5'b00011, imem_addr[10:0]};
  assign imem_data2 = {5'b00011, imem_addr2[10:0]};

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .stallCtrl(stallCtrl), .takeBranch(takeBranch),
    .branchTarget(branchTarget), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_data(imem_data), .instr_IFID(instr_IFID), .PC_IFID(PC_IFID), .PC2_IFID(PC2_IFID),
    .halt_IFID(halt_IFID), .valid_IFID(valid_IFID)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .stallCtrl(stallCtrl), .takeBranch(takeBranch),
    .branchTarget(branchTarget), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdy(imem_rdy),
    .imem_data(imem_data2), .instr_IFID(instr_IFID2), .PC_IFID(PC_IFID2), .PC2_IFID(PC2_IFID2),
    .halt_IFID(halt_IFID2), .valid_IFID(valid_IFID2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_rdy = 1'b0;
    tick(); tick();
    checks++; if (instr_IFID !== 16'h0800) begin failures++; $display("FAIL reset_instr got=%h exp=0800", instr_IFID); end
    checks++; if (PC_IFID !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", PC_IFID); end
    checks++; if (PC2_IFID !== 16'h0000) begin failures++; $display("FAIL reset_pc2 got=%h exp=0000", PC2_IFID); end
    checks++; if (halt_IFID !== 1'b0 || valid_IFID !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", halt_IFID, valid_IFID); end
    checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
    checks++; if (u_dut.state !== RUN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", u_dut.state, RUN); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp;
    rst = 1'b1; imem_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = 16'(2 * i);
      checks++; if (PC_IFID !== exp) begin failures++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, PC_IFID, exp); end
      checks++; if (PC2_IFID !== exp + 16'd2) begin failures++; $display("FAIL zw_pc2[%0d] got=%h exp=%h", i, PC2_IFID, exp + 16'd2); end
      checks++; if (instr_IFID !== (16'h1800 | exp) || valid_IFID !== 1'b1) begin failures++; $display("FAIL zw_instr[%0d] got=%h/%b exp=%h/1", i, instr_IFID, valid_IFID, 16'h1800 | exp); end
    end
  endtask

  task automatic test_wait_state();
    imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) begin failures++; $display("FAIL ws_hold[%0d] got=%b/%h exp=1/0010", i, imem_req, imem_addr); end
      checks++; if (u_dut.state !== WAIT) begin failures++; $display("FAIL ws_state[%0d] got=%0d exp=%0d", i, u_dut.state, WAIT); end
      checks++; if (PC_IFID !== 16'h000E) begin failures++; $display("FAIL ws_ifid[%0d] got=%h exp=000e", i, PC_IFID); end
    end
    imem_rdy = 1'b1;
    tick();
    checks++; if (PC_IFID !== 16'h0010 || PC2_IFID !== 16'h0012) begin failures++; $display("FAIL ws_capture got=%h/%h exp=0010/0012", PC_IFID, PC2_IFID); end
    checks++; if (u_dut.state !== RUN) begin failures++; $display("FAIL ws_run got=%0d exp=%0d", u_dut.state, RUN); end
    imem_rdy = 1'b0;
    tick();
    checks++; if (u_dut.state !== WAIT || imem_addr !== 16'h0012) begin failures++; $display("FAIL ws_wait2 got=%0d/%h exp=%0d/0012", u_dut.state, imem_addr, WAIT); end
  endtask

  task automatic test_branch_wait();
    takeBranch = 1'b1; branchTarget = 16'h0100;
    tick();
    takeBranch = 1'b0;
    checks++; if (instr_IFID !== 16'h0800 || valid_IFID !== 1'b0) begin failures++; $display("FAIL br_bubble got=%h/%b exp=0800/0", instr_IFID, valid_IFID); end
    checks++; if (PC_IFID !== 16'h0000 || PC2_IFID !== 16'h0000) begin failures++; $display("FAIL br_pcs got=%h/%h exp=0000/0000", PC_IFID, PC2_IFID); end
    checks++; if (u_dut.state !== DROP || imem_req !== 1'b0 || imem_addr !== 16'h0100) begin failures++; $display("FAIL br_drop got=%0d/%b/%h exp=%0d/0/0100", u_dut.state, imem_req, imem_addr, DROP); end
    imem_rdy = 1'b1;
    tick();
    checks++; if (u_dut.state !== RUN || valid_IFID !== 1'b0 || instr_IFID !== 16'h0800) begin failures++; $display("FAIL br_stale got=%0d/%b/%h exp=%0d/0/0800", u_dut.state, valid_IFID, instr_IFID, RUN); end
    tick();
    checks++; if (PC_IFID !== 16'h0100 || instr_IFID !== 16'h1900 || valid_IFID !== 1'b1) begin failures++; $display("FAIL br_target got=%h/%h/%b exp=0100/1900/1", PC_IFID, instr_IFID, valid_IFID); end
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_addr = 16'h0104;
    tick();
    checks++; if (PC_IFID !== 16'h0102 || halt_IFID !== 1'b0) begin failures++; $display("FAIL halt_pre got=%h/%b exp=0102/0", PC_IFID, halt_IFID); end
    tick();
    checks++; if (PC_IFID !== 16'h0104 || instr_IFID !== 16'h0000 || halt_IFID !== 1'b1) begin failures++; $display("FAIL halt_cap got=%h/%h/%b exp=0104/0000/1", PC_IFID, instr_IFID, halt_IFID); end
    checks++; if (u_dut.state !== HALT || imem_req !== 1'b0) begin failures++; $display("FAIL halt_state got=%0d/%b exp=%0d/0", u_dut.state, imem_req, HALT); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (PC_IFID !== 16'h0104 || imem_req !== 1'b0 || halt_IFID !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] got=%h/%b/%b exp=0104/0/1", i, PC_IFID, imem_req, halt_IFID); end
    end
    takeBranch = 1'b1; branchTarget = 16'h0040;
    tick();
    takeBranch = 1'b0; halt_en = 1'b0;
    checks++; if (halt_IFID !== 1'b0 || valid_IFID !== 1'b0 || u_dut.state !== RUN || imem_addr !== 16'h0040) begin failures++; $display("FAIL halt_exit got=%b/%b/%0d/%h exp=0/0/%0d/0040", halt_IFID, valid_IFID, u_dut.state, imem_addr, RUN); end
    tick();
    checks++; if (PC_IFID !== 16'h0040 || valid_IFID !== 1'b1 || halt_IFID !== 1'b0) begin failures++; $display("FAIL halt_resume got=%h/%b/%b exp=0040/1/0", PC_IFID, valid_IFID, halt_IFID); end
  endtask

  task automatic test_stall_freeze();
    logic [15:0] exp_addr, exp;
`ifdef FETCH_SKID_EN
    exp_addr = 16'h0044;
`else
    exp_addr = 16'h0042;
`endif
    stallCtrl = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (PC_IFID !== 16'h0040 || instr_IFID !== 16'h1840 || valid_IFID !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=0040/1840/1", i, PC_IFID, instr_IFID, valid_IFID); end
`ifndef FETCH_SKID_EN
      checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0042) begin failures++; $display("FAIL stall_req[%0d] got=%b/%h exp=0/0042", i, imem_req, imem_addr); end
`endif
    end
    stallCtrl = 1'b0; freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (PC_IFID !== 16'h0040 || imem_addr !== exp_addr) begin failures++; $display("FAIL freeze_hold[%0d] got=%h/%h exp=0040/%h", i, PC_IFID, imem_addr, exp_addr); end
    end
    freeze = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 16'h0040 + 16'(2 * i);
      checks++; if (PC_IFID !== exp || instr_IFID !== (16'h1800 | exp)) begin failures++; $display("FAIL sf_resume[%0d] got=%h/%h exp=%h/%h", i, PC_IFID, instr_IFID, exp, 16'h1800 | exp); end
    end
  endtask

  task automatic test_wrap();
    rst = 1'b0; imem_rdy = 1'b0;
    tick();
    checks++; if (imem_addr2 !== 16'hFFFE || PC_IFID2 !== 16'h0000 || valid_IFID2 !== 1'b0) begin failures++; $display("FAIL wrap_reset got=%h/%h/%b exp=fffe/0000/0", imem_addr2, PC_IFID2, valid_IFID2); end
    rst = 1'b1; imem_rdy = 1'b1;
    tick();
    checks++; if (PC_IFID2 !== 16'hFFFE || PC2_IFID2 !== 16'h0000 || instr_IFID2 !== 16'h1FFE) begin failures++; $display("FAIL wrap_cap got=%h/%h/%h exp=fffe/0000/1ffe", PC_IFID2, PC2_IFID2, instr_IFID2); end
    checks++; if (imem_addr2 !== 16'h0000 || imem_req2 !== 1'b1 || halt_IFID2 !== 1'b0) begin failures++; $display("FAIL wrap_next got=%h/%b/%b exp=0000/1/0", imem_addr2, imem_req2, halt_IFID2); end
    tick();
    checks++; if (PC_IFID2 !== 16'h0000 || PC2_IFID2 !== 16'h0002 || valid_IFID2 !== 1'b1) begin failures++; $display("FAIL wrap_after got=%h/%h/%b exp=0000/0002/1", PC_IFID2, PC2_IFID2, valid_IFID2); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; freeze = 1'b1; stallCtrl = 1'b0; takeBranch = 1'b0;
    branchTarget = 16'h0000; imem_rdy = 1'b0; halt_en = 1'b0; halt_addr = 16'h0000;
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_branch_wait();
    test_halt();
    test_stall_freeze();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC loaded at reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 5'b00000, meaning the instr[15:11] value that identifies HALT.
REQ-003 SHALL have parameter NOP_INSTR, default 16'h0800, meaning the bubble instruction written on flush.
REQ-004 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- freeze  in  1  pipeline enable; 1 = advance, 0 = whole pipeline frozen
- stallCtrl  in  1  decode hazard stall; hold PC and IF/ID
- takeBranch  in  1  redirect from EX/MEM
- branchTarget  in  16  redirect PC
- imem_req  out  1  instruction-memory request
- imem_addr  out  16  request address
- imem_rdy  in  1  response valid
- imem_data  in  16  response instruction
- instr_IFID  out  16  IF/ID instruction
- PC_IFID  out  16  IF/ID instruction address
- PC2_IFID  out  16  IF/ID PC+2
- halt_IFID  out  1  IF/ID instruction is HALT
- valid_IFID  out  1  IF/ID holds a real instruction, not a bubble

Function
REQ-005 SHALL implement states RUN, WAIT, DROP and HALT.
REQ-006 SHALL drive imem_req=1 and imem_addr=PC in RUN and WAIT, and imem_req=0 in DROP and HALT.
REQ-007 SHALL hold imem_addr stable from the first request cycle until imem_rdy.
REQ-008 SHALL resolve same-cycle events with priority: reset, then freeze=0, then takeBranch, then stallCtrl, then capture.
REQ-009 SHALL treat freeze=0 as a full hold: state, PC and IF/ID unchanged, and any imem_rdy that cycle ignored.
REQ-010 SHALL on takeBranch: PC<=branchTarget; IF/ID<=NOP_INSTR with valid=0, halt=0, PC_IFID=PC2_IFID=16'h0000; next state RUN, or DROP if a request was issued and not yet answered.
REQ-011 SHALL in DROP discard the next imem_rdy, then return to RUN; a takeBranch in DROP updates PC and stays in DROP.
REQ-012 SHALL on stallCtrl=1 leave PC and IF/ID unchanged and not capture an arriving response, unless FETCH_SKID_EN is defined.
REQ-013 SHALL on capture (imem_rdy in RUN/WAIT, no higher-priority event): instr_IFID<=imem_data, PC_IFID<=PC, PC2_IFID<=PC+2, valid_IFID<=1, PC<=PC+2.
REQ-014 SHALL set halt_IFID<=1 on capture of an instruction whose instr[15:11]==HALT_OPCODE, and enter HALT.
REQ-015 SHALL leave HALT only on takeBranch, per REQ-010.
REQ-016 SHALL enter WAIT from RUN when a request is issued without imem_rdy, and return to RUN on capture.
REQ-017 SHALL support a zero-wait response, with imem_rdy in the same cycle as the request, giving one instruction per cycle.
REQ-018 SHALL compute PC+2 modulo 2^16 (16'hFFFE+2 = 16'h0000), with no error flagged.

Reset
REQ-019 SHALL on rst=0 at a clock edge set: PC=RESET_PC; state=RUN; instr_IFID=NOP_INSTR; PC_IFID=PC2_IFID=16'h0000; halt_IFID=0; valid_IFID=0; skid empty.
REQ-020 SHALL abandon any outstanding memory request on reset, with no DROP.

Configuration
REQ-021 SHALL, with macro FETCH_SKID_EN defined, capture a response that arrives during stallCtrl=1 into a one-entry skid buffer holding data and PC, and stop requesting while the skid is full.
REQ-022 SHALL, with FETCH_SKID_EN defined, load IF/ID from the skid on the first unstalled cycle, issue no memory request that cycle, and empty the skid on takeBranch.
REQ-023 SHALL, without FETCH_SKID_EN, deassert imem_req while stallCtrl=1, unless a request is already outstanding; a response arriving then is discarded and the same PC is refetched.

Structure
REQ-024 SHALL place the state encoding typedef, NOP_INSTR and HALT_OPCODE defaults in the shared pipeline package.
REQ-025 SHALL build IF/ID storage from the existing reg16bit and dff_en registers.
REQ-026 SHALL implement the skid buffer as sub-module fetch_skid.

Verification
REQ-027 SHALL cover zero-wait stream: reset, imem_rdy=1 always -> PC_IFID 0000, 0002, 0004 on consecutive cycles, valid_IFID=1 from cycle 1.
REQ-028 SHALL cover wait-state: imem_rdy delayed 3 cycles at PC 0x0010 -> imem_addr held at 0x0010, state WAIT, then capture with PC2_IFID=0x0012.
REQ-029 SHALL cover branch during WAIT: takeBranch with branchTarget=0x0100 -> IF/ID=0x0800, valid=0; the stale response is dropped; the next capture has PC_IFID=0x0100.
REQ-030 SHALL cover HALT: imem_data=16'h0000 captured -> halt_IFID=1, imem_req=0 thereafter; later takeBranch to 0x0040 -> fetch resumes at 0x0040.
REQ-031 SHALL cover stall and freeze: stallCtrl=1 for 2 cycles, then freeze=0 for 2 cycles -> IF/ID and PC unchanged; the sequence resumes without loss or duplication, in both FETCH_SKID_EN builds.
REQ-032 SHALL cover wrap: RESET_PC=16'hFFFE -> PC2_IFID=16'h0000 and the next fetch address is 16'h0000.
